// File: rtl/nkb2onehot_encoder.sv
// Two-stage valid/ready pipeline that turns an unsigned bit position into a one-hot {B,A} operand pair.
// Define ONEHOT_ENC_OVFCNT_EN to add o_ovf_cnt, a saturating count of overflow results handed downstream.
module nkb2onehot_encoder #(
    parameter int LEN   = 8,
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_y_nkb,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [LEN-1:0]   o_a_oh,
    output logic [LEN-1:0]   o_b_oh,
    output logic             o_overflow,
    output logic             o_err
`ifdef ONEHOT_ENC_OVFCNT_EN
    ,
    output logic [7:0]       o_ovf_cnt
`endif
);

    localparam int OHW   = 2 * LEN;
    localparam int NEEDW = $clog2(OHW) + 1;
    localparam int CMPW  = (WIDTH > NEEDW) ? WIDTH : NEEDW;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_pos_q, s1_pos_d;
    logic             out_valid_q, out_valid_d;
    logic [OHW-1:0]   oh_q, oh_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             stall_q, stall_d;
    logic [WIDTH-1:0] prev_y_q, prev_y_d;

    logic             adv;
    logic             accept;
    logic             move;
    logic [CMPW-1:0]  pos_ext;
    logic [OHW-1:0]   oh_enc;
    logic             ovf_enc;

    assign adv     = !out_valid_q || i_ready;
    assign o_ready = !s1_valid_q || adv;
    assign accept  = i_valid && o_ready;
    assign move    = s1_valid_q && adv;

    // Position is widened before comparing so out-of-range values never alias onto a valid bit.
    always_comb begin
        pos_ext = CMPW'(s1_pos_q);
        ovf_enc = (pos_ext >= CMPW'(OHW));
        oh_enc  = '0;
        for (int i = 0; i < OHW; i++) begin
            oh_enc[i] = (pos_ext == CMPW'(i));
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_pos_d    = s1_pos_q;
        out_valid_d = out_valid_q;
        oh_d        = oh_q;
        ovf_d       = ovf_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_pos_d   = i_y_nkb;
        end else if (move) begin
            s1_valid_d = 1'b0;
        end

        if (move) begin
            out_valid_d = 1'b1;
            oh_d        = oh_enc;
            ovf_d       = ovf_enc;
        end else if (adv) begin
            out_valid_d = 1'b0;
        end

        // A stalled offer must be held unchanged on the next cycle; anything else latches the sticky error.
        stall_d  = i_valid && !o_ready;
        prev_y_d = i_y_nkb;
        err_d    = err_q || (stall_q && (!i_valid || (i_y_nkb != prev_y_q)));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q  <= 1'b0;
            s1_pos_q    <= '0;
            out_valid_q <= 1'b0;
            oh_q        <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
            prev_y_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_pos_q    <= s1_pos_d;
            out_valid_q <= out_valid_d;
            oh_q        <= oh_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            prev_y_q    <= prev_y_d;
        end
    end

`ifdef ONEHOT_ENC_OVFCNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (out_valid_q && i_ready && ovf_q && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_ovf_cnt = ovf_cnt_q;
`endif

    assign o_valid    = out_valid_q;
    assign o_a_oh     = oh_q[LEN-1:0];
    assign o_b_oh     = oh_q[OHW-1:LEN];
    assign o_overflow = ovf_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_nkb2onehot_encoder.sv
// Bench for nkb2onehot_encoder: a LEN=8 and a LEN=6 instance share stimulus and are checked against a
// transaction-level model every cycle, plus directed literal checks.
module tb_nkb2onehot_encoder;

    logic       clk;
    logic       i_rst;
    logic       i_valid;
    logic [3:0] i_y_nkb;
    logic       i_ready;

    logic       rdy8, vld8, ovf8, err8;
    logic [7:0] a8, b8;
    logic       rdy6, vld6, ovf6, err6;
    logic [5:0] a6, b6;
`ifdef ONEHOT_ENC_OVFCNT_EN
    logic [7:0] cnt8, cnt6;
`endif

    int n_compared = 0;
    int n_mismatch = 0;

    nkb2onehot_encoder #(.LEN(8), .WIDTH(4)) dut8 (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (rdy8),
        .i_y_nkb    (i_y_nkb),
        .o_valid    (vld8),
        .i_ready    (i_ready),
        .o_a_oh     (a8),
        .o_b_oh     (b8),
        .o_overflow (ovf8),
        .o_err      (err8)
`ifdef ONEHOT_ENC_OVFCNT_EN
        ,
        .o_ovf_cnt  (cnt8)
`endif
    );

    nkb2onehot_encoder #(.LEN(6), .WIDTH(4)) dut6 (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (rdy6),
        .i_y_nkb    (i_y_nkb),
        .o_valid    (vld6),
        .i_ready    (i_ready),
        .o_a_oh     (a6),
        .o_b_oh     (b6),
        .o_overflow (ovf6),
        .o_err      (err6)
`ifdef ONEHOT_ENC_OVFCNT_EN
        ,
        .o_ovf_cnt  (cnt6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input bit v, input int y, input bit r);
        @(posedge clk);
        #1;
        i_valid = v;
        i_y_nkb = 4'(y);
        i_ready = r;
    endtask

    task automatic wait_sample();
        @(negedge clk);
        #1;
    endtask

    // Expected one-hot halves straight from the position rule.
    function automatic int exp_a(input int p, input int len);
        return (p < len) ? (1 << p) : 0;
    endfunction

    function automatic int exp_b(input int p, input int len);
        return (p >= len && p < 2 * len) ? (1 << (p - len)) : 0;
    endfunction

    int  q_pos[$];
    int  q_acc[$];
    int  cyc = 0;
    int  last_leave = -100;
    bit  err_exp = 1'b0;
    bit  prev_stall = 1'b0;
    int  prev_y = 0;
    int  cnt6_exp = 0;
    int  run = 0;
    int  last_run = 0;
    int  seen_a8[16];
    int  seen_b8[16];
    int  seen_a6[16];
    int  seen_b6[16];
    int  seen_ovf6[16];

    // Model: items in flight form a queue; the head becomes visible two cycles after acceptance or
    // one cycle after its predecessor left, whichever is later. Capacity is two items.
    always @(negedge clk) begin
        int  n;
        int  pos;
        int  vis;
        bit  exp_valid;
        bit  exp_ready;
        if (i_rst) begin
            q_pos.delete();
            q_acc.delete();
            last_leave = -100;
            err_exp    = 1'b0;
            prev_stall = 1'b0;
            prev_y     = 0;
            cnt6_exp   = 0;
        end else begin
            n         = q_pos.size();
            exp_ready = (n < 2) || i_ready;
            exp_valid = 1'b0;
            pos       = 0;
            if (n > 0) begin
                vis = q_acc[0] + 2;
                if (last_leave + 1 > vis) vis = last_leave + 1;
                exp_valid = (cyc >= vis);
                pos       = q_pos[0];
            end
            check_output("ready8", int'(rdy8), int'(exp_ready));
            check_output("ready6", int'(rdy6), int'(exp_ready));
            check_output("valid8", int'(vld8), int'(exp_valid));
            check_output("valid6", int'(vld6), int'(exp_valid));
            check_output("err8", int'(err8), int'(err_exp));
            check_output("err6", int'(err6), int'(err_exp));
            if (exp_valid) begin
                check_output("a8", int'(a8), exp_a(pos, 8));
                check_output("b8", int'(b8), exp_b(pos, 8));
                check_output("ovf8", int'(ovf8), int'(pos >= 16));
                check_output("a6", int'(a6), exp_a(pos, 6));
                check_output("b6", int'(b6), exp_b(pos, 6));
                check_output("ovf6", int'(ovf6), int'(pos >= 12));
                seen_a8[pos]   = int'(a8);
                seen_b8[pos]   = int'(b8);
                seen_a6[pos]   = int'(a6);
                seen_b6[pos]   = int'(b6);
                seen_ovf6[pos] = int'(ovf6);
            end
`ifdef ONEHOT_ENC_OVFCNT_EN
            check_output("ovf_cnt8", int'(cnt8), 0);
            check_output("ovf_cnt6", int'(cnt6), cnt6_exp);
`endif
            if (exp_valid && i_ready) begin
                void'(q_pos.pop_front());
                void'(q_acc.pop_front());
                last_leave = cyc;
                if (pos >= 12 && cnt6_exp < 255) cnt6_exp++;
            end
            if (prev_stall && (!i_valid || int'(i_y_nkb) != prev_y)) err_exp = 1'b1;
            prev_stall = i_valid && !exp_ready;
            prev_y     = int'(i_y_nkb);
            if (i_valid && exp_ready) begin
                q_pos.push_back(int'(i_y_nkb));
                q_acc.push_back(cyc);
            end
        end
        if (vld8) begin
            run++;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        cyc++;
    end

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_y_nkb = 4'd0;
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
        wait_sample();
        check_output("reset_ready", int'(rdy8), 1);
        check_output("reset_valid", int'(vld8), 0);
        check_output("reset_a", int'(a8), 0);
        check_output("reset_b", int'(b8), 0);
        check_output("reset_ovf", int'(ovf8), 0);
        check_output("reset_err", int'(err8), 0);

        // Single value, two-cycle latency, one valid cycle.
        apply_stimulus(1, 3, 1);
        wait_sample();
        apply_stimulus(0, 0, 1);
        wait_sample();
        check_output("lat_not_yet", int'(vld8), 0);
        wait_sample();
        check_output("lat_valid", int'(vld8), 1);
        check_output("lat_a8", int'(a8), 8'h08);
        check_output("lat_b8", int'(b8), 0);
        check_output("lat_ovf", int'(ovf8), 0);
        check_output("lat_a6", int'(a6), 6'h08);
        wait_sample();
        check_output("lat_drop", int'(vld8), 0);

        // Back-to-back stream 0..15.
        for (int p = 0; p < 16; p++) apply_stimulus(1, p, 1);
        apply_stimulus(0, 0, 1);
        repeat (4) wait_sample();
        check_output("stream_run", last_run, 16);
        check_output("pos15_b8", seen_b8[15], 8'h80);
        check_output("pos15_a8", seen_a8[15], 0);
        check_output("pos8_b8", seen_b8[8], 8'h01);
        check_output("pos12_a6", seen_a6[12], 0);
        check_output("pos12_b6", seen_b6[12], 0);
        check_output("pos12_ovf6", seen_ovf6[12], 1);
        check_output("pos11_b6", seen_b6[11], 6'h20);
        check_output("pos11_ovf6", seen_ovf6[11], 0);
`ifdef ONEHOT_ENC_OVFCNT_EN
        check_output("stream_cnt6", int'(cnt6), 4);
`endif

        // Backpressure: 5 then 9 held, then released in order.
        apply_stimulus(1, 5, 0);
        apply_stimulus(1, 9, 0);
        apply_stimulus(0, 9, 0);
        wait_sample();
        check_output("bp_ready", int'(rdy8), 0);
        check_output("bp_valid", int'(vld8), 1);
        check_output("bp_a8", int'(a8), 8'h20);
        apply_stimulus(0, 0, 0);
        apply_stimulus(0, 0, 0);
        wait_sample();
        check_output("bp_hold_a8", int'(a8), 8'h20);
        apply_stimulus(0, 0, 1);
        wait_sample();
        check_output("bp_rel_first", int'(a8), 8'h20);
        wait_sample();
        check_output("bp_rel_second_b8", int'(b8), 8'h02);
        check_output("bp_rel_second_a8", int'(a8), 0);
        wait_sample();
        check_output("bp_empty", int'(vld8), 0);

        // Protocol violation: offer changes from 9 to 2 while stalled.
        apply_stimulus(1, 5, 0);
        apply_stimulus(1, 9, 0);
        apply_stimulus(1, 9, 0);
        apply_stimulus(1, 2, 0);
        wait_sample();
        check_output("err_before", int'(err8), 0);
        apply_stimulus(0, 0, 1);
        wait_sample();
        check_output("err_set", int'(err8), 1);
        repeat (3) wait_sample();
        check_output("err_sticky", int'(err8), 1);

        // Reset with both stages full.
        apply_stimulus(1, 5, 0);
        apply_stimulus(1, 9, 0);
        apply_stimulus(0, 0, 0);
        wait_sample();
        check_output("full_valid", int'(vld8), 1);
        check_output("full_ready", int'(rdy8), 0);
        @(posedge clk);
        #1 i_rst = 1'b1;
        @(posedge clk);
        #1 i_rst = 1'b0;
        i_ready = 1'b1;
        wait_sample();
        check_output("rst2_valid", int'(vld8), 0);
        check_output("rst2_a8", int'(a8), 0);
        check_output("rst2_b8", int'(b8), 0);
        check_output("rst2_err", int'(err8), 0);
        check_output("rst2_ready", int'(rdy8), 1);
        apply_stimulus(1, 1, 1);
        apply_stimulus(0, 0, 1);
        wait_sample();
        wait_sample();
        check_output("post_rst_valid", int'(vld8), 1);
        check_output("post_rst_a8", int'(a8), 8'h02);
        repeat (3) wait_sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/nkb2onehot_encoder.md
Name: nkb2onehot_encoder

Overview:
Sequential inverse of the ALU's one-hot-to-u2 (NKB) decoder. It accepts an unsigned position value and produces a single-hot 2*LEN-bit vector, split into its A half (low LEN bits) and B half (high LEN bits). It sits on the ALU operand side and feeds one-hot operands into the decoder path. It is a two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
LEN, 8, width of each one-hot half; total one-hot vector {B,A} is 2*LEN bits
WIDTH, 4, width of the input position value; must satisfy 2**WIDTH >= 2*LEN is NOT required (values beyond range flag overflow)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  synchronous, active-high reset
i_valid  input  1  upstream has a value on i_y_nkb
o_ready  output  1  encoder accepts a value this cycle
i_y_nkb  input  WIDTH  unsigned bit position in {B,A}
o_valid  output  1  outputs hold a valid result
i_ready  input  1  downstream accepts the result this cycle
o_a_oh  output  LEN  one-hot bits [LEN-1:0] of {B,A}
o_b_oh  output  LEN  one-hot bits [2*LEN-1:LEN] of {B,A}
o_overflow  output  1  result's input was >= 2*LEN (qualified by o_valid)
o_err  output  1  sticky upstream protocol-violation flag

Behaviour:
- Reset (i_rst high at clock edge): o_valid=0, o_a_oh=0, o_b_oh=0, o_overflow=0, o_err=0, stage-1 empty; o_ready=1 the cycle after reset. Reset mid-transfer discards all in-flight data.
- Accept: transfer when i_valid & o_ready at rising edge; value latched into stage 1 (s1_valid=1).
- Advance condition adv = !o_valid | i_ready. Stage 1 moves to the output register when s1_valid & adv; stage 1 refills in the same cycle if a new accept occurs.
- o_ready = !s1_valid | adv (combinational). Full throughput: one result per cycle under no backpressure.
- Latency: value accepted at edge N appears with o_valid=1 after edge N+1 (2 cycles accept-to-visible, counting the accept edge).
- Encoding: pos=i_y_nkb as unsigned. If pos < 2*LEN: exactly bit pos of {o_b_oh,o_a_oh} set, o_overflow=0. If pos >= 2*LEN: {o_b_oh,o_a_oh}=0, o_overflow=1. Width rule: comparison done at max(WIDTH, clog2(2*LEN)+1) bits, no truncation.
- Backpressure: while o_valid & !i_ready, o_a_oh/o_b_oh/o_overflow/o_valid hold stable; stage 1 holds; o_ready=!s1_valid.
- o_valid drops after a transfer (o_valid & i_ready) when stage 1 is empty.
- Protocol check: if the previous cycle had i_valid=1 & o_ready=0, then in the current cycle i_valid=0 or i_y_nkb differing from its previous value sets o_err=1. o_err is sticky until reset and does not block data flow.
- Simultaneous output drain and stage-1 refill in one cycle: both occur; no bubble, no loss.
- No X propagation: outputs are registers, all cleared at reset.

Optional Feature:
ONEHOT_ENC_OVFCNT_EN defined: adds output port o_ovf_cnt [7:0], reset 0, incremented by 1 on each output transfer (o_valid & i_ready) with o_overflow=1, saturating at 255. Cleared only by i_rst. Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then i_y_nkb=3, i_valid 1 cycle, i_ready=1 (LEN=8,WIDTH=4) -> o_valid high exactly one cycle, o_a_oh=8'h08, o_b_oh=8'h00, o_overflow=0, 2-cycle latency.
- Stream 0..15 back-to-back with i_ready=1 -> 16 consecutive o_valid cycles; value 15 gives o_b_oh=8'h80, o_a_oh=0; value 8 gives o_b_oh=8'h01; no bubbles.
- LEN=6, WIDTH=4, input 12 -> o_a_oh=0, o_b_oh=0, o_overflow=1; input 11 -> o_b_oh=6'h20, o_overflow=0; with ONEHOT_ENC_OVFCNT_EN, o_ovf_cnt=1 after transfer.
- Hold i_ready=0, push 5 then 9 -> o_ready=0 after second accept, output frozen at pos 5; release i_ready -> results 5 then 9 delivered in order, nothing lost or duplicated.
- During stall (o_ready=0) change i_y_nkb from 9 to 2 while i_valid=1 -> o_err=1 next cycle and stays 1 until i_rst; data path continues.
- Assert i_rst with both stages full -> next cycle o_valid=0, outputs 0, o_err=0, o_ready=1; subsequent input 1 yields o_a_oh=8'h02.
